// File: rtl/peripheral_dsa_pkg.sv
// Shared constants for the DSA peripheral blocks.
//   DSA_DATA_SIZE : default operand/result width for the modular-arithmetic units.
package peripheral_dsa_pkg;
    localparam int DSA_DATA_SIZE = 32;
endpackage

// File: rtl/peripheral_dsa_modular_multiplier_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one modular multiplier.
// One transaction at a time: grant -> launch -> wait for result (or timeout) ->
// hold the response until the grantee accepts it.
//
// Ports
//   CLK, RST                    clock, async active-low reset
//   REQ_VALID/REQ_READY         per-requester request, one-hot accept pulse
//   REQ_MODULO/DATA_A/DATA_B    flattened operands, requester i at [i*DATA_SIZE +: DATA_SIZE]
//   RSP_VALID/RSP_READY         per-requester response handshake
//   RSP_DATA, RSP_ERROR         shared result; RSP_ERROR marks a timeout (data = 0)
//   MUL_START, MUL_*            multiplier launch pulse and operands
//   MUL_READY, MUL_DATA_OUT     multiplier done flag and result
//   BUSY, GRANT_ID              transaction in flight, current/last grantee
module peripheral_dsa_modular_multiplier_arbiter #(
    parameter int DATA_SIZE = peripheral_dsa_pkg::DSA_DATA_SIZE,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   REQ_MODULO,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   REQ_DATA_A,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   REQ_DATA_B,
    output logic [NUM_REQ-1:0]             REQ_READY,
    output logic [NUM_REQ-1:0]             RSP_VALID,
    input  logic [NUM_REQ-1:0]             RSP_READY,
    output logic [DATA_SIZE-1:0]           RSP_DATA,
    output logic                           RSP_ERROR,
    output logic                           MUL_START,
    output logic [DATA_SIZE-1:0]           MUL_MODULO,
    output logic [DATA_SIZE-1:0]           MUL_DATA_A,
    output logic [DATA_SIZE-1:0]           MUL_DATA_B,
    input  logic                           MUL_READY,
    input  logic [DATA_SIZE-1:0]           MUL_DATA_OUT,
    output logic                           BUSY,
    output logic [$clog2(NUM_REQ)-1:0]     GRANT_ID
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     grant_sel;
    logic [IDW-1:0]     rr_idx;
    logic               req_found;
    logic               seen_low;
    logic [CW-1:0]      wait_cnt;
    logic               mul_done;
    logic               timed_out;

    logic [DATA_SIZE-1:0] req_mod [NUM_REQ];
    logic [DATA_SIZE-1:0] req_a   [NUM_REQ];
    logic [DATA_SIZE-1:0] req_b   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_mod[i] = REQ_MODULO[i*DATA_SIZE +: DATA_SIZE];
        assign req_a[i]   = REQ_DATA_A[i*DATA_SIZE +: DATA_SIZE];
        assign req_b[i]   = REQ_DATA_B[i*DATA_SIZE +: DATA_SIZE];
    end

    // Round-robin search starting one past the previous grantee.
    always_comb begin
        req_found = 1'b0;
        grant_sel = '0;
        rr_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = IDW'((int'(last_grant) + 1 + k) % NUM_REQ);
            if (!req_found && REQ_VALID[rr_idx]) begin
                req_found = 1'b1;
                grant_sel = rr_idx;
            end
        end
    end

    // A READY level left over from the previous operation must not count:
    // completion needs a low sample first.
    assign mul_done  = MUL_READY && seen_low;
    assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
    assign BUSY      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        REQ_READY = '0;
        MUL_START = 1'b0;
        RSP_VALID = '0;
        case (state)
            S_IDLE: begin
                // Accept pulse is combinational; masked while reset is asserted.
                if (req_found && RST) begin
                    REQ_READY[grant_sel] = 1'b1;
                    state_nxt            = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                MUL_START = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done || timed_out) state_nxt = S_RESPOND;
            end
            S_RESPOND: begin
                RSP_VALID[GRANT_ID] = 1'b1;
                if (RSP_READY[GRANT_ID]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            GRANT_ID   <= '0;
            MUL_MODULO <= '0;
            MUL_DATA_A <= '0;
            MUL_DATA_B <= '0;
            RSP_DATA   <= '0;
            RSP_ERROR  <= 1'b0;
            seen_low   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (req_found) begin
                        GRANT_ID   <= grant_sel;
                        MUL_MODULO <= req_mod[grant_sel];
                        MUL_DATA_A <= req_a[grant_sel];
                        MUL_DATA_B <= req_b[grant_sel];
                    end
                end
                S_LAUNCH: begin
                    seen_low <= 1'b0;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (mul_done) begin
                        RSP_DATA  <= MUL_DATA_OUT;
                        RSP_ERROR <= 1'b0;
                    end else if (timed_out) begin
                        RSP_DATA  <= '0;
                        RSP_ERROR <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (!MUL_READY) seen_low <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (RSP_READY[GRANT_ID]) last_grant <= GRANT_ID;
                end
                default: ;
            endcase
        end
    end

endmodule
